// File: rtl/vga_pkg.sv
// vga_pkg: pattern codes, sequencer state encoding and default dwell shared by the VGA pattern sequencer.
package vga_pkg;
  localparam logic [1:0] PAT_COLORBAR = 2'd0;
  localparam logic [1:0] PAT_GRAY = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;
  localparam int DWELL_FRAMES_DEFAULT = 60;
  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_PEND = 2'd1,
    S_APPLY = 2'd2
  } state_t;
endpackage

// File: rtl/vga_frame_edge.sv
// vga_frame_edge: registers video_vs and emits a one-cycle frame_start on each sync assertion.
module vga_frame_edge #(
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic video_vs,
  output logic frame_start
);
  logic vs_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= ~VS_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      vs_prev <= video_vs;
      frame_start <= (video_vs == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
    end
  end
endmodule

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: steps pattern_sel on manual or dwell-timed requests, only at frame boundaries.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_FRAMES = DWELL_FRAMES_DEFAULT,
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       video_vs,
  input  logic       video_de,
  input  logic       next_req,
  input  logic       auto_en,
  input  logic       freeze,
  output logic [1:0] pattern_sel,
  output logic       frame_start,
  output logic       switch_pending,
  output logic [7:0] frame_cnt
);
  state_t state, state_nxt;
  logic [7:0] dwell_cnt;
  logic expire;
  logic unused_de;
  assign unused_de = video_de;
  vga_frame_edge #(.VS_ACTIVE(VS_ACTIVE)) u_edge (
    .clk(clk),
    .rst_n(rst_n),
    .video_vs(video_vs),
    .frame_start(frame_start)
  );
  // Auto expiry wins over a coincident manual request, so only one advance results.
  assign expire = auto_en && !freeze && frame_start && (dwell_cnt == 8'(DWELL_FRAMES - 1));
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   state_nxt = freeze ? S_RUN : expire ? S_APPLY : next_req ? S_PEND : S_RUN;
      S_PEND:  state_nxt = (frame_start && !freeze) ? S_APPLY : S_PEND;
      default: state_nxt = S_RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      pattern_sel <= PAT_COLORBAR;
      switch_pending <= 1'b0;
      frame_cnt <= 8'd0;
      dwell_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (frame_start) frame_cnt <= frame_cnt + 8'd1;
      if (state == S_APPLY)
        pattern_sel <= (pattern_sel == 2'(NUM_PATTERNS - 1)) ? PAT_COLORBAR : pattern_sel + 2'd1;
      switch_pending <= (state_nxt == S_PEND) || (switch_pending && state_nxt == S_APPLY);
      dwell_cnt <= (!auto_en || state == S_APPLY) ? 8'd0 :
                   (state == S_RUN && !freeze && frame_start && !expire) ? dwell_cnt + 8'd1 : dwell_cnt;
    end
  end
endmodule
